mdu_result_stage: RTL and testbench

//  Downstream companion of the partial-product multiplier. It carries MDU control from Execute to Memory,

---
 rtl/mdu_result_stage_if.sv | 25 ++
 rtl/mdu_result_stage.sv | 95 +++++++++
 tb/tb_mdu_result_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_result_stage_if.sv
// rtl/mdu_result_stage_if.sv - MDU operand/control and result bundle between pipeline and result stage
interface mdu_result_stage_if #(
    parameter int XLEN = 64
);
    logic              MDUActiveE;
    logic [2:0]        Funct3E;
    logic              W64E;
    logic [2*XLEN-1:0] ProdM;
    logic [XLEN-1:0]   QuotM;
    logic [XLEN-1:0]   RemM;
    logic [2:0]        Funct3M;
    logic              MDUActiveM;
    logic [XLEN-1:0]   MDUResultW;
    logic              MDUValidW;

    modport master (
        output MDUActiveE, Funct3E, W64E, ProdM, QuotM, RemM,
        input  Funct3M, MDUActiveM, MDUResultW, MDUValidW
    );

    modport slave (
        input  MDUActiveE, Funct3E, W64E, ProdM, QuotM, RemM,
        output Funct3M, MDUActiveM, MDUResultW, MDUValidW
    );
endinterface

// File: rtl/mdu_result_stage.sv
// rtl/mdu_result_stage.sv - MDU control pipelining E->M, result select/format in M, result register in W
module mdu_result_stage #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallM,
    input  logic              FlushM,
    input  logic              StallW,
    input  logic              FlushW,
    mdu_result_stage_if.slave bus
);
    logic            active_m_q, active_m_d;
    logic [2:0]      funct3_m_q, funct3_m_d;
    logic            w64_m_q, w64_m_d;
    logic            valid_w_q, valid_w_d;
    logic [XLEN-1:0] result_w_q, result_w_d;
    logic [XLEN-1:0] sel_m;
    logic [XLEN-1:0] result_m;

    // Enable/clear next-state; reset is applied separately with top priority.
    always_comb begin
        active_m_d = active_m_q;
        funct3_m_d = funct3_m_q;
        w64_m_d    = w64_m_q;
        if (!StallM) begin
            if (FlushM) begin
                active_m_d = 1'b0;
                funct3_m_d = 3'b000;
                w64_m_d    = 1'b0;
            end else begin
                active_m_d = bus.MDUActiveE;
                funct3_m_d = bus.Funct3E;
                w64_m_d    = bus.W64E;
            end
        end
    end

    always_comb begin
        sel_m = '0;
        case (funct3_m_q)
            3'b000:                 sel_m = bus.ProdM[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel_m = bus.ProdM[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel_m = bus.QuotM;
            default:                sel_m = bus.RemM;
        endcase
    end

    // Word ops always sign-extend bit 31, even the unsigned DIVUW/REMUW forms.
    generate
        if (XLEN == 64) begin : g_w64
            always_comb begin
                result_m = sel_m;
                if (w64_m_q) result_m = {{(XLEN-32){sel_m[31]}}, sel_m[31:0]};
            end
        end else begin : g_no_w64
            always_comb result_m = sel_m;
        end
    endgenerate

    always_comb begin
        valid_w_d  = valid_w_q;
        result_w_d = result_w_q;
        if (!StallW) begin
            if (FlushW) begin
                valid_w_d  = 1'b0;
                result_w_d = '0;
            end else begin
                valid_w_d  = active_m_q;
                result_w_d = result_m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_m_q <= 1'b0;
            funct3_m_q <= 3'b000;
            w64_m_q    <= 1'b0;
            valid_w_q  <= 1'b0;
            result_w_q <= '0;
        end else begin
            active_m_q <= active_m_d;
            funct3_m_q <= funct3_m_d;
            w64_m_q    <= w64_m_d;
            valid_w_q  <= valid_w_d;
            result_w_q <= result_w_d;
        end
    end

    assign bus.Funct3M    = funct3_m_q;
    assign bus.MDUActiveM = active_m_q;
    assign bus.MDUResultW = result_w_q;
    assign bus.MDUValidW  = valid_w_q;
endmodule

// File: tb/tb_mdu_result_stage.sv
// tb/tb_mdu_result_stage.sv - randomized and directed checks of mdu_result_stage against a reference model
module tb_mdu_result_stage;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic reset, StallM, FlushM, StallW, FlushW;
    int   vectors = 0;
    int   miscompares = 0;

    mdu_result_stage_if #(.XLEN(XLEN)) bus ();

    mdu_result_stage #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .StallM (StallM),
        .FlushM (FlushM),
        .StallW (StallW),
        .FlushW (FlushW),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference state: what each pipeline register should hold after the last edge.
    logic       ref_act_m;
    logic [2:0] ref_f3_m;
    logic       ref_w64_m;
    logic       ref_val_w;
    logic [63:0] ref_res_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mdu_value(input logic [2:0] f3, input logic w64,
                                              input logic [127:0] prod, input logic [63:0] quot,
                                              input logic [63:0] rem);
        logic [63:0]        v;
        logic signed [31:0] lo;
        if (f3 == 3'd0)      v = 64'(prod % (128'd1 << 64));
        else if (f3 <= 3'd3) v = 64'(prod >> 64);
        else if (f3 <= 3'd5) v = quot;
        else                 v = rem;
        if (w64) begin
            lo = v[31:0];
            v  = 64'(lo);
        end
        return v;
    endfunction

    // One clock: check outputs mid-cycle, advance the model with the inputs present at the edge.
    task automatic cycle();
        logic       n_act, n_w64, n_val;
        logic [2:0] n_f3;
        logic [63:0] n_res;
        @(negedge clk);
        check("Funct3M", 64'(bus.Funct3M), 64'(ref_f3_m));
        check("MDUActiveM", 64'(bus.MDUActiveM), 64'(ref_act_m));
        check("MDUValidW", 64'(bus.MDUValidW), 64'(ref_val_w));
        check("MDUResultW", bus.MDUResultW, ref_res_w);
        n_act = ref_act_m; n_f3 = ref_f3_m; n_w64 = ref_w64_m;
        n_val = ref_val_w; n_res = ref_res_w;
        if (reset) begin
            n_act = 0; n_f3 = 0; n_w64 = 0; n_val = 0; n_res = 0;
        end else begin
            if (!StallW) begin
                n_val = FlushW ? 1'b0 : ref_act_m;
                n_res = FlushW ? 64'd0 : mdu_value(ref_f3_m, ref_w64_m, bus.ProdM, bus.QuotM, bus.RemM);
            end
            if (!StallM) begin
                n_act = FlushM ? 1'b0 : bus.MDUActiveE;
                n_f3  = FlushM ? 3'd0 : bus.Funct3E;
                n_w64 = FlushM ? 1'b0 : bus.W64E;
            end
        end
        @(posedge clk);
        #1;
        ref_act_m = n_act; ref_f3_m = n_f3; ref_w64_m = n_w64;
        ref_val_w = n_val; ref_res_w = n_res;
    endtask

    task automatic present(input logic act, input logic [2:0] f3, input logic w64);
        bus.MDUActiveE = act;
        bus.Funct3E    = f3;
        bus.W64E       = w64;
    endtask

    initial begin
        reset = 1; StallM = 0; FlushM = 0; StallW = 0; FlushW = 0;
        present(0, 3'd0, 0);
        bus.ProdM = '0; bus.QuotM = '0; bus.RemM = '0;
        ref_act_m = 0; ref_f3_m = 0; ref_w64_m = 0; ref_val_w = 0; ref_res_w = 0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        reset = 0;
        check("reset_res", bus.MDUResultW, 64'd0);
        check("reset_val", 64'(bus.MDUValidW), 64'd0);

        // MUL low half
        present(1, 3'd0, 0);
        cycle();
        present(0, 3'd0, 0);
        bus.ProdM = 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE;
        cycle();
        check("mul", bus.MDUResultW, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mul_valid", 64'(bus.MDUValidW), 64'd1);

        // StallW freezes W while the inputs churn
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ProdM = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            check("stallw_hold", bus.MDUResultW, 64'hFFFF_FFFF_FFFF_FFFE);
        end
        StallW = 0;

        present(1, 3'd1, 0);
        cycle();
        present(0, 3'd0, 0);
        bus.ProdM = 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE;
        cycle();
        check("mulh", bus.MDUResultW, 64'h0000_0000_0000_0001);

        present(1, 3'd0, 1);
        cycle();
        present(0, 3'd0, 0);
        bus.ProdM = {64'hDEAD_BEEF_0000_0000, 64'h1234_5678_8000_0000};
        cycle();
        check("mulw", bus.MDUResultW, 64'hFFFF_FFFF_8000_0000);

        present(1, 3'd7, 1);
        cycle();
        present(0, 3'd0, 0);
        bus.RemM = 64'h0000_0000_7FFF_FFFF;
        cycle();
        check("remuw", bus.MDUResultW, 64'h0000_0000_7FFF_FFFF);

        // Flush under stall is ignored, then a real flush drains one edge later
        present(1, 3'd5, 0);
        cycle();
        StallM = 1; FlushM = 1;
        present(1, 3'd2, 0);
        cycle();
        check("stallm_f3", 64'(bus.Funct3M), 64'd5);
        check("stallm_act", 64'(bus.MDUActiveM), 64'd1);
        StallM = 0;
        cycle();
        check("flushm_act", 64'(bus.MDUActiveM), 64'd0);
        check("flushm_w_valid", 64'(bus.MDUValidW), 64'd1);
        FlushM = 0;
        present(0, 3'd0, 0);
        cycle();
        check("flushm_drain", 64'(bus.MDUValidW), 64'd0);

        // Reset beats stalls
        present(1, 3'd3, 0);
        cycle();
        cycle();
        reset = 1; StallM = 1; StallW = 1;
        cycle();
        check("rst_mid_val", 64'(bus.MDUValidW), 64'd0);
        check("rst_mid_act", 64'(bus.MDUActiveM), 64'd0);
        reset = 0; StallM = 0; StallW = 0;

        for (int i = 0; i < 400; i++) begin
            present($urandom_range(0, 1), 3'($urandom), 1'($urandom));
            bus.ProdM  = {$urandom, $urandom, $urandom, $urandom};
            bus.QuotM  = {$urandom, $urandom};
            bus.RemM   = {$urandom, $urandom};
            StallM     = ($urandom_range(0, 4) == 0);
            FlushM     = ($urandom_range(0, 5) == 0);
            StallW     = ($urandom_range(0, 4) == 0);
            FlushW     = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
